// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, encoded lengths, loader error
// causes and the encoder FSM state type.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] LEN_1  = 4'd1;
  localparam logic [3:0] LEN_2  = 4'd2;
  localparam logic [3:0] LEN_9  = 4'd9;
  localparam logic [3:0] LEN_10 = 4'd10;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ICODE = 2'd1,
    ERR_OVF   = 2'd2
  } err_code_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/y86_instr_len.sv
// Combinational icode -> encoded byte length lookup; valid is low for
// icodes outside the Y86-64 instruction set.
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] len,
  output logic       valid
);

  always_comb begin
    len   = 4'd0;
    valid = 1'b1;
    case (icode)
      I_HALT, I_NOP, I_RET:                 len = LEN_1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:     len = LEN_2;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:         len = LEN_10;
      I_JXX, I_CALL:                        len = LEN_9;
      default:                              valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/y86_instr_encoder.sv
// Serializes one Y86-64 instruction per handshake into byte writes that the
// fetch stage decodes back into the same icode/ifun/rA/rB/valC fields.
module y86_instr_encoder
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 4096,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    icode,
  input  logic [3:0]    ifun,
  input  logic [3:0]    rA,
  input  logic [3:0]    rB,
  input  logic [63:0]   valC,
  input  logic          set_ptr,
  input  logic [AW-1:0] ptr_val,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic [AW-1:0] wr_ptr,
  output logic          busy,
  output logic          err,
  output logic [1:0]    err_code
);

  state_t    state, state_nx;
  err_code_t err_code_r;

  logic [3:0]  len_in;
  logic        len_ok;
  logic [AW:0] end_addr;
  logic        overflow, accept, go, last;
  logic [3:0]  k, k_nx;

  logic [3:0]  len_p0, icode_p0, ifun_p0, ra_p0, rb_p0;
  logic [63:0] valc_p0;

  // Byte idx of the image. jXX/call carry valC in bytes 1..8, the other
  // long forms in bytes 2..9; both MSB first.
  function automatic logic [7:0] byte_sel(input logic [3:0] ic, input logic [3:0] fn,
                                          input logic [3:0] ra, input logic [3:0] rb,
                                          input logic [63:0] vc, input logic [3:0] idx);
    logic [63:0] sh;
    logic [3:0]  slot;
    sh       = '0;
    slot     = '0;
    byte_sel = {ic, fn};
    if (idx != 4'd0) begin
      if (ic == I_JXX || ic == I_CALL) begin
        slot     = 4'd8 - idx;
        sh       = vc >> {slot, 3'b000};
        byte_sel = sh[7:0];
      end else if (idx == 4'd1) begin
        byte_sel = {ra, rb};
      end else begin
        slot     = 4'd9 - idx;
        sh       = vc >> {slot, 3'b000};
        byte_sel = sh[7:0];
      end
    end
  endfunction

  y86_instr_len u_len (
    .icode (icode),
    .len   (len_in),
    .valid (len_ok)
  );

  // Overflow test is done one bit wider so an exact fit is not mistaken for wrap.
  assign end_addr = {1'b0, wr_ptr} + {{(AW-3){1'b0}}, len_in};
  assign overflow = end_addr > (AW+1)'(MEM_BYTES);
  assign accept   = in_valid & in_ready;
  assign go       = accept & len_ok & ~overflow;
  assign k_nx     = k + 4'd1;
  assign last     = (k_nx == len_p0);
  assign err_code = err_code_r;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (go)   state_nx = S_EMIT;
      S_EMIT:  if (last) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == S_IDLE) & ~set_ptr & ~reset;
    busy     = (state == S_EMIT);
  end

  // Control and output stage: byte 0 is registered on the accept edge itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      err        <= 1'b0;
      err_code_r <= ERR_NONE;
      k          <= '0;
    end else begin
      mem_we     <= 1'b0;
      err        <= 1'b0;
      err_code_r <= ERR_NONE;
      case (state)
        S_IDLE: begin
          if (set_ptr) begin
            wr_ptr <= ptr_val;
          end else if (accept) begin
            if (!len_ok) begin
              err        <= 1'b1;
              err_code_r <= ERR_ICODE;
            end else if (overflow) begin
              err        <= 1'b1;
              err_code_r <= ERR_OVF;
            end else begin
              mem_we    <= 1'b1;
              mem_addr  <= wr_ptr;
              mem_wdata <= byte_sel(icode, ifun, rA, rB, valC, 4'd0);
              k         <= 4'd0;
            end
          end
        end
        S_EMIT: begin
          if (last) begin
            wr_ptr <= wr_ptr + {{(AW-4){1'b0}}, len_p0};
          end else begin
            k         <= k_nx;
            mem_we    <= 1'b1;
            mem_addr  <= wr_ptr + {{(AW-4){1'b0}}, k_nx};
            mem_wdata <= byte_sel(icode_p0, ifun_p0, ra_p0, rb_p0, valc_p0, k_nx);
          end
        end
        default: ;
      endcase
    end
  end

  // Field capture: held for the whole emission, inputs ignored afterwards.
  always_ff @(posedge clk) begin
    if (go) begin
      len_p0   <= len_in;
      icode_p0 <= icode;
      ifun_p0  <= ifun;
      ra_p0    <= rA;
      rb_p0    <= rB;
      valc_p0  <= valC;
    end
  end

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Scoreboard bench for y86_instr_encoder: a byte-image reference model fills
// expected-write and expected-error queues that a negedge monitor drains.
module tb_y86_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, set_ptr;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC;
  logic [11:0] ptr_val, mem_addr, wr_ptr;
  logic        mem_we, busy, err;
  logic [7:0]  mem_wdata;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  y86_instr_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
    .set_ptr(set_ptr), .ptr_val(ptr_val), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .wr_ptr(wr_ptr), .busy(busy), .err(err), .err_code(err_code)
  );

  typedef struct packed {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_err[$];
  int  checks = 0;
  int  errors = 0;
  int  model_ptr = 0;
  bit  mon_en = 1'b0;
  int  len_tab[16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 0, 0, 0, 0};

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    int  c;
    if (mon_en) begin
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h, required no write", mem_addr, mem_wdata);
        end else begin
          e = exp_wr.pop_front();
          check("write", {mem_addr, mem_wdata}, {e.a, e.d});
        end
      end
      if (err) begin
        if (exp_err.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_err: got code %0d, required no err", err_code);
        end else begin
          c = exp_err.pop_front();
          check("err_code", err_code, c);
        end
      end
    end
  end

  // Reference: length table plus the byte image assembled field by field.
  task automatic model(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] vc, output int exp_len);
    int         l;
    logic [7:0] img[$];
    l = len_tab[ic];
    exp_len = 0;
    if (l == 0) begin
      exp_err.push_back(1);
    end else if (model_ptr + l > 4096) begin
      exp_err.push_back(2);
    end else begin
      img.push_back({ic, fn});
      if (ic != 4'h7 && ic != 4'h8 && l >= 2) img.push_back({ra, rb});
      if (l >= 9) for (int i = 7; i >= 0; i--) img.push_back(vc[8*i +: 8]);
      foreach (img[j]) exp_wr.push_back('{a: 12'(model_ptr + j), d: img[j]});
      model_ptr = (model_ptr + l) % 4096;
      exp_len = l;
    end
  endtask

  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc);
    int el;
    int n;
    model(ic, fn, ra, rb, vc, el);
    icode = ic; ifun = fn; rA = ra; rB = rb; valC = vc;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!in_ready && n < 40) begin
      {icode, ifun, rA, rB} = 16'($urandom);
      valC = {$urandom, $urandom};
      @(negedge clk);
      n++;
    end
    check("ready_latency", n, (el == 0) ? 1 : el + 1);
    check("wr_ptr", wr_ptr, model_ptr);
  endtask

  task automatic load_ptr(input int v, input bit with_instr);
    if (with_instr) begin
      icode = 4'h3; ifun = 4'h0; rA = 4'hF; rB = 4'h4; valC = 64'h100;
      in_valid = 1'b1;
    end
    set_ptr = 1'b1;
    ptr_val = 12'(v);
    #1 check("ready_in_setptr", in_ready, 0);
    @(negedge clk);
    set_ptr  = 1'b0;
    in_valid = 1'b0;
    model_ptr = v;
    check("wr_ptr_set", wr_ptr, v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dummy;
    reset = 1'b1; in_valid = 1'b0; set_ptr = 1'b0; ptr_val = '0;
    icode = '0; ifun = '0; rA = '0; rB = '0; valC = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_ptr", wr_ptr, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    send(4'h3, 4'h0, 4'hF, 4'h4, 64'h100);
    send(4'h0, 4'h0, 4'h0, 4'h0, {$urandom, $urandom});
    send(4'h2, 4'h0, 4'h1, 4'h2, {$urandom, $urandom});
    load_ptr(0, 1'b0);
    send(4'h8, 4'h0, 4'h0, 4'h0, 64'h0A0B);
    send(4'hC, 4'h0, 4'h1, 4'h2, 64'h55);
    load_ptr(4090, 1'b0);
    send(4'h3, 4'h0, 4'hF, 4'h4, 64'h100);
    load_ptr(12'h200, 1'b1);
    load_ptr(4086, 1'b0);
    send(4'h5, 4'h0, 4'h1, 4'h2, {$urandom, $urandom});
    load_ptr(4087, 1'b0);
    send(4'h7, 4'h3, 4'h0, 4'h0, {$urandom, $urandom});

    // Reset during an irmov: only the first three bytes may land.
    load_ptr(0, 1'b0);
    model(4'h3, 4'h0, 4'hF, 4'h4, 64'h1122334455667788, dummy);
    while (exp_wr.size() > 3) void'(exp_wr.pop_back());
    icode = 4'h3; ifun = 4'h0; rA = 4'hF; rB = 4'h4; valC = 64'h1122334455667788;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_writes_left", exp_wr.size(), 0);
    check("abort_mem_we", mem_we, 0);
    check("abort_wr_ptr", wr_ptr, 0);
    check("abort_busy", busy, 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_mem_wdata", mem_wdata, 0);
    reset = 1'b0;
    model_ptr = 0;
    @(negedge clk);

    for (int it = 0; it < 40; it++) begin
      logic [3:0] ic;
      if ($urandom_range(0, 5) == 0)
        load_ptr(($urandom_range(0, 1) == 0) ? $urandom_range(4080, 4095) : $urandom_range(0, 4095), 1'b0);
      ic = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 11));
      send(ic, 4'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom});
    end

    repeat (3) @(negedge clk);
    check("drain_writes", exp_wr.size(), 0);
    check("drain_errs", exp_err.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/y86_instr_encoder.md
# y86_instr_encoder

Serializes one Y86-64 instruction per handshake into byte-wide writes to the 4096-byte instruction memory that the SEQ fetch stage reads. It is the write-side counterpart of fetch: it takes decoded fields (icode, ifun, rA, rB, valC) and emits the exact byte image that fetch decodes back into the same fields. It is used as a hardware program loader for benches and boot, driven by a testbench or a host port.

## Interface
- `MEM_BYTES`, 4096: instruction memory size in bytes; the address width is log2 of this value (12).
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: instruction fields valid.
- `in_ready`  out  1: block accepts fields this cycle.
- `icode`  in  4: instruction code.
- `ifun`  in  4: function code.
- `rA`  in  4: register specifier A.
- `rB`  in  4: register specifier B.
- `valC`  in  64: constant or destination.
- `set_ptr`  in  1: load the write pointer.
- `ptr_val`  in  12: new write pointer value.
- `mem_we`  out  1: byte write strobe (registered).
- `mem_addr`  out  12: byte address (registered).
- `mem_wdata`  out  8: byte data (registered).
- `wr_ptr`  out  12: next free byte address.
- `busy`  out  1: emission in progress.
- `err`  out  1: one-cycle pulse on a rejected instruction.
- `err_code`  out  2: error cause, valid with `err`. 1 = invalid icode, 2 = overflow.

## Operation
- FSM states: IDLE and EMIT.
- `in_ready` = (state==IDLE) & !`set_ptr` & !`reset`. This is combinational.
- `set_ptr` in IDLE: `wr_ptr` <= `ptr_val`. `set_ptr` is ignored in EMIT. When `set_ptr` and `in_valid` arrive together in IDLE, `set_ptr` wins and no instruction is accepted.
- On accept (`in_valid` & `in_ready`), the block computes len from icode:
  - 0 (halt), 1 (nop), 9 (ret): len 1.
  - 2 (cmov), 6 (OP), A (push), B (pop): len 2.
  - 3 (irmov), 4 (rmmov), 5 (mrmov): len 10.
  - 7 (jXX), 8 (call): len 9.
- If icode is greater than B: pulse `err`, `err_code`=1, write nothing, stay in IDLE.
- If `wr_ptr` + len > 4096 (13-bit compare, no wrap): pulse `err`, `err_code`=2, write nothing, leave `wr_ptr` unchanged.
- Otherwise: latch the fields, set byte index k=0, and enter EMIT.
- Byte image, with byte k written at `wr_ptr`+k:
  - Byte 0 is {icode,ifun}.
  - Register forms: byte 1 is {rA,rB}. The block writes rA and rB as given, with no 0xF substitution.
  - irmov, rmmov, mrmov: bytes 2..9 = valC[63:56] .. valC[7:0], most-significant byte first. This matches fetch's `valC`=bytes[2..9] concatenation.
  - jXX, call: bytes 1..8 = valC[63:56] .. valC[7:0].
- In EMIT, the block writes one byte per cycle and increments k. On the last byte (k==len-1) it sets `wr_ptr` <= `wr_ptr`+len and returns to IDLE.
- Input fields are not sampled during EMIT. Changes to them have no effect.

## Timing
- Accept at edge T. Bytes k=0..len-1 appear on `mem_*` with `mem_we`=1 during cycles T+1 .. T+len.
- `wr_ptr` updates at the end of the last byte cycle. `in_ready` is high again in cycle T+len+1.
- Throughput is len+1 cycles per instruction.
- `err` is registered and asserts in cycle T+1 after a rejecting accept. A reject costs one cycle and leaves `mem_we` at 0.
- `busy`=1 exactly while in EMIT.
- Reset values: state IDLE, `wr_ptr`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `err`=0, `err_code`=0.
- Reset mid-EMIT: the block aborts at once and writes no further bytes after the reset edge. Bytes already written remain in memory, and `wr_ptr` becomes 0.
- Exact fit: `wr_ptr`+len == 4096 is legal. `wr_ptr` then becomes 0 through 12-bit wrap, and `busy` deasserts normally.

## Structure
- Shared package `y86_pkg` holds:
  - The icode constants `I_HALT` .. `I_POPQ` (0..B).
  - The length constants 1, 2, 9 and 10.
  - The `err_code` enum.
  - The FSM state typedef.
- One sub-module, `y86_instr_len`: combinational lookup from icode to {len[3:0], valid}. It is reused by the fetch stage and the disassembler monitor.
- The byte select is a mux on k and icode class. It needs no shift register.

## Test plan
- irmov with `wr_ptr`=0, fields 3/0/F/4, valC=0x100. Required writes: addr 0..9 = 30 F4 00 00 00 00 00 00 01 00, then `wr_ptr`=10 and `in_ready` high in cycle T+11.
- Back-to-back halt then `rrmovq` (2/0/1/2) at `wr_ptr`=10. Required: addr 10=00, then addr 11..12 = 20 12, `wr_ptr`=13.
- call (8/0) with valC=0x0000_0000_0000_0A0B at `wr_ptr`=0. Required: 9 bytes 80 00 00 00 00 00 00 0A 0B, `wr_ptr`=9.
- icode=C. Required: `err`=1 with `err_code`=1 in T+1, no `mem_we`, `wr_ptr` unchanged. Then set `ptr_val`=4090 and send irmov. Required: `err_code`=2, no writes, `wr_ptr`=4090.
- `set_ptr` and `in_valid` in the same IDLE cycle with `ptr_val`=0x200. Required: `in_ready`=0, `wr_ptr`=0x200, and no write that cycle.
- Reset asserted in the 4th byte cycle of an irmov. Required: exactly 3 writes (addr 0..2), then all outputs at reset values.
